// File: rtl/bp_be_prefetch_scheduler.sv
// Stride prefetch sequencer: tracks per-PC load streams written by the RPT and
// issues their prefetch addresses round-robin to the dcache, one per cycle.

module bp_be_prefetch_entry #(
  parameter int vaddr_width_p       = 39,
  parameter int page_offset_width_p = 12,
  parameter int rem_width_p         = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          flush,
  input  logic                                          wr,
  input  logic                                          adv,
  input  logic [vaddr_width_p-1:0]                      trig_pc,
  input  logic [vaddr_width_p-1:0]                      wr_next,
  input  logic [vaddr_width_p-1:0]                      wr_stride,
  input  logic [vaddr_width_p-page_offset_width_p-1:0]  wr_page,
  input  logic [rem_width_p-1:0]                        wr_rem,
  output logic                                          v,
  output logic                                          hit,
  output logic                                          elig,
  output logic                                          active,
  output logic [vaddr_width_p-1:0]                      next_addr
);
  localparam logic [rem_width_p-1:0] one = rem_width_p'(1);

  logic [vaddr_width_p-1:0]                     pc;
  logic [vaddr_width_p-1:0]                     stride;
  logic [vaddr_width_p-page_offset_width_p-1:0] base_page;
  logic [rem_width_p-1:0]                       remaining;
  logic                                         on_page;

  assign on_page = next_addr[vaddr_width_p-1:page_offset_width_p] == base_page;
  assign active  = v & (remaining != '0);
  assign elig    = active & on_page;
  assign hit     = v & (pc == trig_pc);

  // Priority: flush > trigger write > issue advance > page-exit invalidate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v         <= 1'b0;
      pc        <= '0;
      next_addr <= '0;
      stride    <= '0;
      base_page <= '0;
      remaining <= '0;
    end else if (flush) begin
      v <= 1'b0;
    end else if (wr) begin
      v         <= 1'b1;
      pc        <= trig_pc;
      next_addr <= wr_next;
      stride    <= wr_stride;
      base_page <= wr_page;
      remaining <= wr_rem;
    end else if (adv) begin
      next_addr <= next_addr + stride;
      remaining <= remaining - one;
      v         <= (remaining != one);
    end else if (active & ~on_page) begin
      v <= 1'b0;
    end
  end
endmodule

module bp_be_prefetch_scheduler #(
  parameter int vaddr_width_p       = 39,
  parameter int stride_width_p      = 8,
  parameter int streams_p           = 4,
  parameter int degree_p            = 4,
  parameter int page_offset_width_p = 12
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      init_done_i,
  input  logic                      stride_v_i,
  input  logic [stride_width_p-1:0] stride_i,
  input  logic [vaddr_width_p-1:0]  pc_i,
  input  logic [vaddr_width_p-1:0]  eff_addr_i,
  input  logic                      confirm_i,
  input  logic                      flush_i,
  output logic                      pf_v_o,
  output logic [vaddr_width_p-1:0]  pf_addr_o,
  input  logic                      pf_ready_i,
  output logic                      drop_o,
  output logic                      busy_o
);
  localparam int rem_w = $clog2(2*degree_p+1);
  localparam int idx_w = $clog2(streams_p);

  logic [streams_p-1:0]                    v, hit, elig, active, wr, adv;
  logic [streams_p-1:0][vaddr_width_p-1:0] next_addr;
  logic [idx_w-1:0]                        rr, win, cand, free_idx;
  logic                                    any_elig, any_free, any_hit, accept, load;
  logic [vaddr_width_p-1:0]                stride_sext, wr_next;
  logic [rem_w-1:0]                        wr_rem;

  assign stride_sext = {{(vaddr_width_p-stride_width_p){stride_i[stride_width_p-1]}}, stride_i};
  assign wr_next     = eff_addr_i + stride_sext;
  assign wr_rem      = confirm_i ? rem_w'(2*degree_p) : rem_w'(degree_p);
  assign accept      = stride_v_i & init_done_i & ~flush_i & (stride_i != '0);
  assign any_hit     = |hit;
  assign load        = (~pf_v_o | pf_ready_i) & any_elig;
  assign busy_o      = (|active) | pf_v_o;

  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = streams_p-1; i >= 0; i--) begin
      if (!v[i]) begin
        any_free = 1'b1;
        free_idx = idx_w'(i);
      end
    end
  end

  // First eligible entry at or after rr, wrapping.
  always_comb begin
    any_elig = 1'b0;
    win      = rr;
    cand     = rr;
    for (int k = 0; k < streams_p; k++) begin
      cand = rr + idx_w'(k);
      if (!any_elig && elig[cand]) begin
        any_elig = 1'b1;
        win      = cand;
      end
    end
  end

  always_comb begin
    wr  = '0;
    adv = '0;
    for (int i = 0; i < streams_p; i++) begin
      wr[i]  = accept & (any_hit ? hit[i] : (any_free & (free_idx == idx_w'(i))));
      adv[i] = load & (win == idx_w'(i));
    end
  end

  for (genvar g = 0; g < streams_p; g++) begin : g_ent
    bp_be_prefetch_entry #(
      .vaddr_width_p(vaddr_width_p),
      .page_offset_width_p(page_offset_width_p),
      .rem_width_p(rem_w)
    ) u_ent (
      .clk(clk_i), .rst_n(reset_n_i), .flush(flush_i), .wr(wr[g]), .adv(adv[g]),
      .trig_pc(pc_i), .wr_next(wr_next), .wr_stride(stride_sext),
      .wr_page(eff_addr_i[vaddr_width_p-1:page_offset_width_p]), .wr_rem(wr_rem),
      .v(v[g]), .hit(hit[g]), .elig(elig[g]), .active(active[g]), .next_addr(next_addr[g])
    );
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pf_v_o    <= 1'b0;
      pf_addr_o <= '0;
      drop_o    <= 1'b0;
      rr        <= '0;
    end else begin
      drop_o <= accept & ~any_hit & ~any_free;
      if (flush_i) begin
        pf_v_o <= 1'b0;
      end else if (load) begin
        pf_v_o    <= 1'b1;
        pf_addr_o <= next_addr[win];
        rr        <= win + idx_w'(1);
      end else if (pf_ready_i) begin
        pf_v_o <= 1'b0;
      end
    end
  end
endmodule
